mdr_op_scheduler: RTL and testbench



---
 rtl/mdr_pkg.sv | 42 ++++
 rtl/mdr_op_scheduler_if.sv | 38 +++
 rtl/mdr_timeout_counter.sv | 35 +++
 rtl/mdr_op_scheduler.sv | 148 ++++++++++++++
 tb/tb_mdr_op_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdr_pkg.sv
// Shared types and constants for the MDR operation scheduler.
// Op codes double as the engine index for the one-hot start vector.
package mdr_pkg;

  localparam int unsigned DefaultDw      = 16;
  localparam int unsigned DefaultTimeout = 64;
  localparam int unsigned NumEng         = 3;

  localparam int unsigned EngMul  = 0;
  localparam int unsigned EngDiv  = 1;
  localparam int unsigned EngSqrt = 2;

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpDiv  = 2'b01,
    OpSqrt = 2'b10,
    OpInv  = 2'b11
  } mdr_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StLoadY,
    StDispatch,
    StWait,
    StDone,
    StErr
  } mdr_state_e;

  function automatic logic [NumEng-1:0] eng_onehot(input mdr_op_e op);
    logic [NumEng-1:0] oh;
    oh = '0;
    case (op)
      OpMul:   oh[EngMul]  = 1'b1;
      OpDiv:   oh[EngDiv]  = 1'b1;
      OpSqrt:  oh[EngSqrt] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mdr_op_scheduler_if.sv
// Host and engine-side signal bundle of the MDR scheduler.
// The scheduler uses the slave view; the host/engine side uses the master view.
interface mdr_op_scheduler_if #(
  parameter int unsigned DW = mdr_pkg::DefaultDw
);

  logic              start;
  logic [1:0]        op;
  logic              load;
  logic [DW-1:0]     data;
  logic              busy;
  logic              load_x;
  logic              load_y;
  logic [1:0]        eng_sel;
  logic [2:0]        eng_start;
  logic [DW-1:0]     eng_x;
  logic [DW-1:0]     eng_y;
  logic [2:0]        eng_ready;
  logic [2*DW-1:0]   eng_res;
  logic [DW-1:0]     eng_rem;
  logic [2*DW-1:0]   result;
  logic [DW-1:0]     remainder;
  logic              ready;
  logic              error;

  modport slave (
    input  start, op, load, data, eng_ready, eng_res, eng_rem,
    output busy, load_x, load_y, eng_sel, eng_start, eng_x, eng_y,
    output result, remainder, ready, error
  );

  modport master (
    output start, op, load, data, eng_ready, eng_res, eng_rem,
    input  busy, load_x, load_y, eng_sel, eng_start, eng_x, eng_y,
    input  result, remainder, ready, error
  );

endinterface

// File: rtl/mdr_timeout_counter.sv
// Clear/enable up-counter with a terminal-count flag at TIMEOUT-1.
module mdr_timeout_counter #(
  parameter int unsigned TIMEOUT = mdr_pkg::DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_op_scheduler.sv
// MDR operation sequencer: collects operands, starts one engine, waits for
// its ready under a timeout, and latches the result. All outputs are registered.
module mdr_op_scheduler
  import mdr_pkg::*;
#(
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic             clk,
  input logic             rst,
  mdr_op_scheduler_if.slave bus
);

  mdr_state_e      state_q, state_d;
  mdr_op_e         sel_q, sel_d;
  logic [DW-1:0]   x_q, x_d, y_q, y_d;
  logic [2*DW-1:0] res_q, res_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            load_x_q, load_x_d;
  logic            load_y_q, load_y_d;
  logic [2:0]      eng_start_q, eng_start_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;

  logic cnt_en, cnt_tc, sel_ready;

  // Counter runs through DISPATCH and WAIT so it reads 1 in the first WAIT cycle,
  // making ERR land exactly TIMEOUT cycles after DISPATCH.
  assign cnt_en    = (state_q == StDispatch) || (state_q == StWait);
  assign sel_ready = |(eng_onehot(sel_q) & bus.eng_ready);

  mdr_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!cnt_en),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    rem_d   = rem_q;
    error_d = error_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          sel_d   = mdr_op_e'(bus.op);
          error_d = 1'b0;
          state_d = (mdr_op_e'(bus.op) == OpInv) ? StErr : StLoadX;
        end
      end
      StLoadX: begin
        if (bus.load) begin
          x_d = bus.data;
          if (sel_q == OpSqrt) begin
            y_d     = '0;
            state_d = StDispatch;
          end else begin
            state_d = StLoadY;
          end
        end
      end
      StLoadY: begin
        if (bus.load) begin
          y_d     = bus.data;
          state_d = ((sel_q == OpDiv) && (bus.data == '0)) ? StErr : StDispatch;
        end
      end
      StDispatch: state_d = StWait;
      StWait: begin
        // Ready takes priority over a coincident timeout.
        if (sel_ready) begin
          res_d   = bus.eng_res;
          rem_d   = (sel_q == OpMul) ? '0 : bus.eng_rem;
          state_d = StDone;
        end else if (cnt_tc) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StErr) begin
      error_d = 1'b1;
      res_d   = '0;
      rem_d   = '0;
    end

    busy_d      = (state_d != StIdle);
    load_x_d    = (state_d == StLoadX);
    load_y_d    = (state_d == StLoadY);
    eng_start_d = (state_d == StDispatch) ? eng_onehot(sel_d) : 3'b000;
    ready_d     = (state_d == StDone) || (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sel_q       <= OpMul;
      x_q         <= '0;
      y_q         <= '0;
      res_q       <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      load_x_q    <= 1'b0;
      load_y_q    <= 1'b0;
      eng_start_q <= 3'b000;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_q       <= res_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      load_x_q    <= load_x_d;
      load_y_q    <= load_y_d;
      eng_start_q <= eng_start_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.load_x    = load_x_q;
  assign bus.load_y    = load_y_q;
  assign bus.eng_sel   = sel_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_x     = x_q;
  assign bus.eng_y     = y_q;
  assign bus.result    = res_q;
  assign bus.remainder = rem_q;
  assign bus.ready     = ready_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_mdr_op_scheduler.sv
// Self-checking bench for mdr_op_scheduler: directed cases plus randomized
// operations against an arithmetic reference model acting as the engines.
module tb_mdr_op_scheduler;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 64;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;

  mdr_op_scheduler_if #(.DW(DW)) bus ();

  mdr_op_scheduler #(
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] isqrt(input logic [15:0] v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 16'(r);
  endfunction

  task automatic gap_load(input string tag, input bit want_x);
    int g;
    g = int'($urandom_range(0, 2));
    for (int i = 0; i < g; i++) begin
      tick();
      if (want_x) chk({tag, "_hold_x"}, 64'(bus.load_x), 64'd1);
      else        chk({tag, "_hold_y"}, 64'(bus.load_y), 64'd1);
    end
  endtask

  // One full operation; the bench plays both host and engine.
  task automatic do_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       input int lat, input bit hang, input bit noise);
    logic [31:0] exp_res;
    logic [15:0] exp_rem;
    logic [2:0]  sel_bit;
    logic [15:0] r;
    bit          bad;
    int          done_k;

    bad     = (op == 2'd3) || (op == 2'd1 && y == 16'd0);
    sel_bit = (op == 2'd3) ? 3'b000 : 3'(1 << op);
    exp_res = '0;
    exp_rem = '0;
    case (op)
      2'd0: exp_res = {16'd0, x} * {16'd0, y};
      2'd1: if (y != 16'd0) begin
        exp_res = {16'd0, x / y};
        exp_rem = x % y;
      end
      2'd2: begin
        r       = isqrt(x);
        exp_res = {16'd0, r};
        exp_rem = x - r * r;
      end
      default: ;
    endcase

    bus.start = 1'b1;
    bus.op    = op;
    tick();
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("error_after_start", 64'(bus.error), 64'(op == 2'd3));

    if (op == 2'd3) begin
      chk("inv_ready", 64'(bus.ready), 64'd1);
      chk("inv_eng_start", 64'(bus.eng_start), 64'd0);
      chk("inv_load_x", 64'(bus.load_x), 64'd0);
      tick();
      chk("inv_ready_pulse", 64'(bus.ready), 64'd0);
      chk("inv_idle", 64'(bus.busy), 64'd0);
      chk("inv_error_held", 64'(bus.error), 64'd1);
      return;
    end

    chk("load_x", 64'(bus.load_x), 64'd1);
    chk("load_y_early", 64'(bus.load_y), 64'd0);
    gap_load("lx", 1'b1);
    bus.load = 1'b1;
    bus.data = x;
    tick();
    bus.load = 1'b0;
    bus.data = 16'($urandom);

    if (op != 2'd2) begin
      chk("load_y", 64'(bus.load_y), 64'd1);
      chk("load_x_drop", 64'(bus.load_x), 64'd0);
      gap_load("ly", 1'b0);
      bus.load = 1'b1;
      bus.data = y;
      tick();
      bus.load = 1'b0;
      bus.data = 16'($urandom);
    end

    if (bad) begin
      chk("dz_ready", 64'(bus.ready), 64'd1);
      chk("dz_error", 64'(bus.error), 64'd1);
      chk("dz_eng_start", 64'(bus.eng_start), 64'd0);
      chk("dz_result", 64'(bus.result), 64'd0);
      tick();
      chk("dz_ready_pulse", 64'(bus.ready), 64'd0);
      chk("dz_idle", 64'(bus.busy), 64'd0);
      chk("dz_error_held", 64'(bus.error), 64'd1);
      return;
    end

    chk("dispatch_start", 64'(bus.eng_start), 64'(sel_bit));
    chk("dispatch_sel", 64'(bus.eng_sel), 64'(op));
    chk("dispatch_x", 64'(bus.eng_x), 64'(x));
    chk("dispatch_y", 64'(bus.eng_y), (op == 2'd2) ? 64'd0 : 64'(y));
    chk("dispatch_load_y", 64'(bus.load_y), 64'd0);

    done_k = hang ? int'(TO) : lat + 1;
    for (int k = 1; k <= int'(TO) + 2; k++) begin
      tick();
      if (k == 1) begin
        chk("eng_start_single", 64'(bus.eng_start), 64'd0);
        chk("wait_error_clear", 64'(bus.error), 64'd0);
      end
      if (k == done_k) begin
        bus.eng_ready = 3'b000;
        bus.start     = 1'b0;
        bus.load      = 1'b0;
        chk("done_ready", 64'(bus.ready), 64'd1);
        chk("done_error", 64'(bus.error), 64'(hang));
        chk("done_result", 64'(bus.result), hang ? 64'd0 : 64'(exp_res));
        chk("done_remainder", 64'(bus.remainder), hang ? 64'd0 : 64'(exp_rem));
        chk("done_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("ready_pulse", 64'(bus.ready), 64'd0);
        chk("back_idle", 64'(bus.busy), 64'd0);
        chk("error_after_op", 64'(bus.error), 64'(hang));
        return;
      end
      chk("ready_early", 64'(bus.ready), 64'd0);
      bus.eng_ready = noise ? (3'($urandom) & ~sel_bit) : 3'b000;
      bus.eng_res   = $urandom;
      bus.eng_rem   = 16'($urandom);
      if (!hang && k == lat) begin
        bus.eng_ready = bus.eng_ready | sel_bit;
        bus.eng_res   = exp_res;
        if (op != 2'd0) bus.eng_rem = exp_rem;
      end
      if (noise) begin
        bus.start = 1'($urandom);
        bus.op    = 2'($urandom);
        bus.load  = 1'($urandom);
      end
    end
    chk("done_reached", 64'd0, 64'd1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [15:0] rx, ry;

    n_asserts     = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.load      = 1'b0;
    bus.data      = '0;
    bus.eng_ready = 3'b000;
    bus.eng_res   = '0;
    bus.eng_rem   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_load_x", 64'(bus.load_x), 64'd0);
    chk("rst_eng_start", 64'(bus.eng_start), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    rst = 1'b1;
    tick();

    do_op(2'd0, 16'd7, 16'd6, 4, 1'b0, 1'b0);
    do_op(2'd1, 16'd100, 16'd0, 3, 1'b0, 1'b0);
    tick();
    chk("error_sticky_idle", 64'(bus.error), 64'd1);
    do_op(2'd2, 16'd81, 16'd1234, 3, 1'b0, 1'b0);
    do_op(2'd0, 16'd3, 16'd5, 1, 1'b1, 1'b0);
    do_op(2'd3, 16'd1, 16'd1, 1, 1'b0, 1'b0);
    do_op(2'd0, 16'd1000, 16'd2000, 10, 1'b0, 1'b1);
    do_op(2'd1, 16'd50000, 16'd3, int'(TO) - 1, 1'b0, 1'b0);
    do_op(2'd2, 16'd65535, 16'd0, 1, 1'b0, 1'b1);

    // Reset while waiting on a DIV engine.
    bus.start = 1'b1;
    bus.op    = 2'd1;
    tick();
    bus.start = 1'b0;
    bus.load  = 1'b1;
    bus.data  = 16'd200;
    tick();
    bus.data  = 16'd5;
    tick();
    bus.load  = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_eng_sel", 64'(bus.eng_sel), 64'd0);
    chk("arst_eng_x", 64'(bus.eng_x), 64'd0);
    chk("arst_eng_y", 64'(bus.eng_y), 64'd0);
    chk("arst_result", 64'(bus.result), 64'd0);
    chk("arst_remainder", 64'(bus.remainder), 64'd0);
    chk("arst_ready", 64'(bus.ready), 64'd0);
    chk("arst_error", 64'(bus.error), 64'd0);
    bus.eng_ready = 3'b010;
    tick();
    rst = 1'b1;
    tick();
    bus.eng_ready = 3'b000;
    chk("post_rst_ready", 64'(bus.ready), 64'd0);
    chk("post_rst_idle", 64'(bus.busy), 64'd0);
    do_op(2'd1, 16'd100, 16'd7, 6, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      rop = 2'($urandom_range(0, 3));
      rx  = 16'($urandom);
      ry  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      do_op(rop, rx, ry, int'($urandom_range(1, TO - 1)), ($urandom_range(0, 7) == 0),
            1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rand_idle_gap", 64'(bus.busy), 64'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
